// File: rtl/atsc_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : atsc_rx_pkg
// Description : Shared constants for the ATSC RX depadder: settings-bus
//               addresses, reset configuration, readback select codes and
//               counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package atsc_rx_pkg;

    // Settings-bus register addresses
    localparam int c_sr_keep   = 129;
    localparam int c_sr_offset = 130;
    localparam int c_sr_clr    = 131;

    // One MPEG-TS packet is 188 bytes, i.e. 47 words at 32 bits
    localparam int c_atsc_ts_bytes    = 188;
    localparam int c_default_keep   = 47;
    localparam int c_default_offset = 0;

    // Statistics counters wrap at this width
    localparam int c_cnt_w = 32;

    // Readback select codes
    typedef enum logic [7:0] {
        RB_CFG      = 8'd0,
        RB_PKTS_IN  = 8'd1,
        RB_PKTS_OUT = 8'd2,
        RB_SHORT    = 8'd3,
        RB_LONG     = 8'd4
    } rb_sel_e;

endpackage
`default_nettype wire

// File: rtl/axis_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_reg
// Description : Two-entry AXI-Stream skid buffer. The upstream ready is a
//               register (skid slot empty), so there is no combinational
//               path from downstream ready back upstream. Full throughput
//               with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_reg #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data
);

    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_s_ready;

    logic w_s_hs;
    logic w_m_free;
    logic w_skid_valid_nxt;

    assign w_s_hs   = i_s_valid & r_s_ready;
    // Output slot can take a new word when empty or being consumed this cycle
    assign w_m_free = i_m_ready | ~r_m_valid;
    // Skid slot fills only when a word arrives while the output slot is held
    assign w_skid_valid_nxt = w_m_free ? 1'b0 : (r_skid_valid | w_s_hs);

    // Output slot, skid slot and registered upstream ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_s_ready    <= 1'b0;
        end else begin
            r_s_ready    <= ~w_skid_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_m_free) begin
                if (r_skid_valid) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= r_skid_data;
                end else begin
                    r_m_valid <= w_s_hs;
                    if (w_s_hs) begin
                        r_m_data <= i_s_data;
                    end
                end
            end else if (w_s_hs) begin
                r_skid_data <= i_s_data;
            end
        end
    end

    assign o_s_ready = r_s_ready;
    assign o_m_valid = r_m_valid;
    assign o_m_data  = r_m_data;

endmodule
`default_nettype wire

// File: rtl/atsc_depad_cfg.sv
`default_nettype none
// ============================================================================
// Module      : atsc_depad_cfg
// Description : Runtime-configurable AXI-Stream depadder. Per input packet it
//               drops OFFSET leading words, forwards KEEP words and drops the
//               remainder; flags short/long packets and exposes counters on
//               a registered readback bus.
// Revision    : 1.0 - initial release
// ============================================================================
module atsc_depad_cfg
    import atsc_rx_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 8,
    parameter int SR_KEEP        = c_sr_keep,
    parameter int SR_OFFSET      = c_sr_offset,
    parameter int SR_CLR         = c_sr_clr,
    parameter int DEFAULT_KEEP   = c_default_keep,
    parameter int DEFAULT_OFFSET = c_default_offset
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              set_stb,
    input  logic [7:0]        set_addr,
    input  logic [31:0]       set_data,
    input  logic [DATA_W-1:0] in_TDATA,
    input  logic              in_TVALID,
    output logic              in_TREADY,
    input  logic              in_TLAST,
    output logic [DATA_W-1:0] out_TDATA,
    output logic              out_TVALID,
    input  logic              out_TREADY,
    output logic              out_TLAST,
    input  logic [7:0]        rb_addr,
    output logic [63:0]       rb_data
);

    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_keep;
    logic [CNT_W-1:0]   r_off;
    logic [CNT_W-1:0]   r_keep_sh;
    logic [CNT_W-1:0]   r_off_sh;
    logic               r_long_seen;
    logic [c_cnt_w-1:0] r_pkts_in;
    logic [c_cnt_w-1:0] r_pkts_out;
    logic [c_cnt_w-1:0] r_short;
    logic [c_cnt_w-1:0] r_long;
    logic [63:0]        r_rb;

    logic             w_hs;
    logic             w_first;
    logic [CNT_W-1:0] w_keep;
    logic [CNT_W-1:0] w_off;
    logic [CNT_W:0]   w_end;
    logic [CNT_W:0]   w_idx_x;
    logic             w_keep_nz;
    logic             w_in_win;
    logic             w_last_win;
    logic             w_past;
    logic             w_short_inc;
    logic             w_long_inc;
    logic             w_out_last_hs;
    logic             w_clr;
    logic             w_wr_keep;
    logic             w_wr_off;
    logic             w_unused_set_data;

    assign w_hs    = in_TVALID & in_TREADY;
    // The first word of a packet sees the shadow values it is about to load
    assign w_first = (r_idx == '0);
    assign w_keep  = w_first ? r_keep_sh : r_keep;
    assign w_off   = w_first ? r_off_sh  : r_off;

    // Window end is one bit wider so OFFSET+KEEP never wraps
    assign w_end      = {1'b0, w_off} + {1'b0, w_keep};
    assign w_idx_x    = {1'b0, r_idx};
    assign w_keep_nz  = |w_keep;
    assign w_in_win   = (r_idx >= w_off) && (w_idx_x < w_end);
    assign w_last_win = (w_idx_x == (w_end - 1'b1));
    assign w_past     = w_keep_nz && (w_idx_x >= w_end);

    assign w_short_inc   = w_hs & in_TLAST & w_keep_nz & (w_idx_x < (w_end - 1'b1));
    assign w_long_inc    = w_hs & w_past & ~r_long_seen;
    assign w_out_last_hs = out_TVALID & out_TREADY & out_TLAST;

    assign w_clr     = set_stb && (set_addr == 8'(SR_CLR));
    assign w_wr_keep = set_stb && (set_addr == 8'(SR_KEEP));
    assign w_wr_off  = set_stb && (set_addr == 8'(SR_OFFSET));

    assign w_unused_set_data = &{1'b0, set_data[31:CNT_W]};

    axis_skid_reg #(
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .i_s_valid (in_TVALID & w_in_win),
        .o_s_ready (in_TREADY),
        .i_s_data  ({in_TLAST | w_last_win, in_TDATA}),
        .o_m_valid (out_TVALID),
        .i_m_ready (out_TREADY),
        .o_m_data  ({out_TLAST, out_TDATA})
    );

    // Config shadow writes, per-packet activation, word index and long flag
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_keep_sh   <= CNT_W'(DEFAULT_KEEP);
            r_off_sh    <= CNT_W'(DEFAULT_OFFSET);
            r_keep      <= CNT_W'(DEFAULT_KEEP);
            r_off       <= CNT_W'(DEFAULT_OFFSET);
            r_idx       <= '0;
            r_long_seen <= 1'b0;
        end else begin
            if (w_wr_keep) begin
                r_keep_sh <= set_data[CNT_W-1:0];
            end
            if (w_wr_off) begin
                r_off_sh <= set_data[CNT_W-1:0];
            end
            if (w_hs) begin
                if (w_first) begin
                    r_keep <= r_keep_sh;
                    r_off  <= r_off_sh;
                end
                if (in_TLAST) begin
                    r_idx       <= '0;
                    r_long_seen <= 1'b0;
                end else begin
                    if (r_idx != {CNT_W{1'b1}}) begin
                        r_idx <= r_idx + 1'b1;
                    end
                    r_long_seen <= r_long_seen | w_past;
                end
            end
        end
    end

    // Statistics counters; a clear strobe overrides any same-cycle increment
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_pkts_in  <= '0;
            r_pkts_out <= '0;
            r_short    <= '0;
            r_long     <= '0;
        end else if (w_clr) begin
            r_pkts_in  <= '0;
            r_pkts_out <= '0;
            r_short    <= '0;
            r_long     <= '0;
        end else begin
            if (w_hs && in_TLAST) begin
                r_pkts_in <= r_pkts_in + 1'b1;
            end
            if (w_out_last_hs) begin
                r_pkts_out <= r_pkts_out + 1'b1;
            end
            if (w_short_inc) begin
                r_short <= r_short + 1'b1;
            end
            if (w_long_inc) begin
                r_long <= r_long + 1'b1;
            end
        end
    end

    // Registered readback mux
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rb <= '0;
        end else begin
            case (rb_addr)
                RB_CFG:      r_rb <= {32'(r_keep_sh), 32'(r_off_sh)};
                RB_PKTS_IN:  r_rb <= 64'(r_pkts_in);
                RB_PKTS_OUT: r_rb <= 64'(r_pkts_out);
                RB_SHORT:    r_rb <= 64'(r_short);
                RB_LONG:     r_rb <= 64'(r_long);
                default:     r_rb <= '0;
            endcase
        end
    end

    assign rb_data = r_rb;

endmodule
`default_nettype wire

// File: tb/tb_atsc_depad_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_atsc_depad_cfg
// Description : Directed and randomised self-checking bench for the ATSC
//               depadder: window selection, short/long packets, config
//               timing, stall behaviour, counters and mid-packet reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_atsc_depad_cfg;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              set_stb = 1'b0;
    logic [7:0]        set_addr = '0;
    logic [31:0]       set_data = '0;
    logic [DATA_W-1:0] in_TDATA = '0;
    logic              in_TVALID = 1'b0;
    logic              in_TREADY;
    logic              in_TLAST = 1'b0;
    logic [DATA_W-1:0] out_TDATA;
    logic              out_TVALID;
    logic              out_TREADY = 1'b1;
    logic              out_TLAST;
    logic [7:0]        rb_addr = '0;
    logic [63:0]       rb_data;

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    bit          rand_mode = 1'b0;
    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    longint      got_cyc[$];
    logic [31:0] pkt_data[$];
    longint      first_hs_cyc;
    longint      last_hs_cyc;
    logic        stall_prev = 1'b0;
    logic [32:0] stall_word = '0;

    atsc_depad_cfg u_dut (
        .ap_clk     (clk),
        .ap_rst_n   (ap_rst_n),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .in_TDATA   (in_TDATA),
        .in_TVALID  (in_TVALID),
        .in_TREADY  (in_TREADY),
        .in_TLAST   (in_TLAST),
        .out_TDATA  (out_TDATA),
        .out_TVALID (out_TVALID),
        .out_TREADY (out_TREADY),
        .out_TLAST  (out_TLAST),
        .rb_addr    (rb_addr),
        .rb_data    (rb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: constant 1 or 50% random
    always @(posedge clk) begin
        #1;
        out_TREADY = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor plus hold-under-stall check
    always @(negedge clk) begin
        if (ap_rst_n && stall_prev) begin
            checks++;
            if (!out_TVALID || {out_TLAST, out_TDATA} !== stall_word) begin
                errors++;
                $display("FAIL stall_hold got valid=%0b word=%h exp valid=1 word=%h",
                         out_TVALID, {out_TLAST, out_TDATA}, stall_word);
            end
        end
        stall_prev = ap_rst_n && out_TVALID && !out_TREADY;
        stall_word = {out_TLAST, out_TDATA};
        if (ap_rst_n && out_TVALID && out_TREADY) begin
            got_q.push_back({out_TLAST, out_TDATA});
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input int addr, input logic [31:0] val);
        set_stb  = 1'b1;
        set_addr = 8'(addr);
        set_data = val;
        @(posedge clk); #1;
        set_stb  = 1'b0;
    endtask

    task automatic rd_rb(input int addr, output logic [63:0] val);
        rb_addr = 8'(addr);
        @(posedge clk); #1;
        val = rb_data;
    endtask

    // Sends words 0..n-1 of a len-word packet from pkt_data; optional
    // settings write issued together with word cfg_at
    task automatic send_pkt(input int n, input int len, input int gap_pct,
                            input int cfg_at, input int cfg_addr, input logic [31:0] cfg_val);
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                in_TVALID = 1'b0;
                @(posedge clk); #1;
            end
            in_TVALID = 1'b1;
            in_TDATA  = pkt_data[i];
            in_TLAST  = (i == len - 1);
            if (i == cfg_at) begin
                set_stb  = 1'b1;
                set_addr = 8'(cfg_addr);
                set_data = cfg_val;
            end
            ok = 1'b0;
            for (int w = 0; w < 1000 && !ok; w++) begin
                @(negedge clk);
                ok = in_TREADY;
                if (ok) begin
                    if (i == 0) first_hs_cyc = cyc;
                    last_hs_cyc = cyc;
                end
                @(posedge clk); #1;
                set_stb = 1'b0;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout word=%0d got ready=0 exp ready=1", i);
                break;
            end
        end
        in_TVALID = 1'b0;
        in_TLAST  = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 400 && got_q.size() < exp_q.size(); w++) begin
            @(posedge clk); #1;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp(input int len, input logic [31:0] base);
        pkt_data.delete();
        for (int i = 0; i < len; i++) pkt_data.push_back(base + 32'(i));
    endtask

    task automatic test_reset();
        logic [63:0] v;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_TVALID, out_TLAST, in_TREADY} !== 3'b000 || out_TDATA !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b last=%0b ready=%0b data=%h exp all 0",
                     out_TVALID, out_TLAST, in_TREADY, out_TDATA);
        end
        ap_rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_TREADY !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %0b exp 1", in_TREADY);
        end
        rd_rb(0, v);
        checks++;
        if (v !== 64'h0000002F_00000000) begin
            errors++;
            $display("FAIL reset_cfg got %h exp 0000002f00000000", v);
        end
        for (int a = 1; a <= 5; a++) begin
            rd_rb(a, v);
            checks++;
            if (v !== 64'd0) begin
                errors++;
                $display("FAIL reset_rb%0d got %h exp 0", a, v);
            end
        end
    endtask

    task automatic test_defaults();
        logic [63:0] v;
        longint      f0;
        logic [63:0] exp_cnt [1:4];
        exp_cnt[1] = 2; exp_cnt[2] = 2; exp_cnt[3] = 0; exp_cnt[4] = 2;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        fill_ramp(64, 0);
        send_pkt(64, 64, 0, -1, 0, 0);
        f0 = first_hs_cyc;
        send_pkt(64, 64, 0, -1, 0, 0);
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 47; i++) exp_q.push_back({i == 46, 32'(i)});
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL defaults_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL defaults_word%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        checks++;
        if (last_hs_cyc - f0 != 127) begin
            errors++;
            $display("FAIL input_rate got %0d cycles exp 127", last_hs_cyc - f0);
        end
        if (got_cyc.size() == 94) begin
            checks++;
            if (got_cyc[0] != f0 + 1 || got_cyc[46] - got_cyc[0] != 46 ||
                got_cyc[47] - got_cyc[46] != 18 || got_cyc[93] - got_cyc[47] != 46) begin
                errors++;
                $display("FAIL output_timing got lat=%0d span0=%0d gap=%0d span1=%0d exp 1 46 18 46",
                         got_cyc[0] - f0, got_cyc[46] - got_cyc[0],
                         got_cyc[47] - got_cyc[46], got_cyc[93] - got_cyc[47]);
            end
        end
        for (int a = 1; a <= 4; a++) begin
            rd_rb(a, v);
            checks++;
            if (v !== exp_cnt[a]) begin
                errors++;
                $display("FAIL defaults_rb%0d got %0d exp %0d", a, v, exp_cnt[a]);
            end
        end
    endtask

    task automatic test_offset();
        logic [63:0] v;
        logic [63:0] exp_cnt [1:4];
        exp_cnt[1] = 1; exp_cnt[2] = 1; exp_cnt[3] = 0; exp_cnt[4] = 0;
        set_cfg(131, 0);
        for (int a = 1; a <= 4; a++) begin
            rd_rb(a, v);
            checks++;
            if (v !== 64'd0) begin
                errors++;
                $display("FAIL clear_rb%0d got %0d exp 0", a, v);
            end
        end
        set_cfg(130, 4);
        rd_rb(0, v);
        checks++;
        if (v !== 64'h0000002F_00000004) begin
            errors++;
            $display("FAIL offset_cfg got %h exp 0000002f00000004", v);
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        fill_ramp(51, 32'h1000);
        send_pkt(51, 51, 0, -1, 0, 0);
        for (int i = 4; i <= 50; i++) exp_q.push_back({i == 50, 32'h1000 + 32'(i)});
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL offset_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL offset_word%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        for (int a = 1; a <= 4; a++) begin
            rd_rb(a, v);
            checks++;
            if (v !== exp_cnt[a]) begin
                errors++;
                $display("FAIL offset_rb%0d got %0d exp %0d", a, v, exp_cnt[a]);
            end
        end
    endtask

    task automatic test_short();
        logic [63:0] v;
        logic [63:0] exp_cnt [1:4];
        exp_cnt[1] = 2; exp_cnt[2] = 1; exp_cnt[3] = 2; exp_cnt[4] = 0;
        set_cfg(131, 0);
        set_cfg(130, 0);
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        fill_ramp(20, 0);
        send_pkt(20, 20, 0, -1, 0, 0);
        for (int i = 0; i < 20; i++) exp_q.push_back({i == 19, 32'(i)});
        set_cfg(130, 4);
        fill_ramp(3, 32'h2000);
        send_pkt(3, 3, 0, -1, 0, 0);
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL short_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL short_word%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        for (int a = 1; a <= 4; a++) begin
            rd_rb(a, v);
            checks++;
            if (v !== exp_cnt[a]) begin
                errors++;
                $display("FAIL short_rb%0d got %0d exp %0d", a, v, exp_cnt[a]);
            end
        end
    endtask

    task automatic test_cfg_midpacket();
        logic [63:0] v;
        logic [63:0] exp_cnt [0:4];
        exp_cnt[0] = 0; exp_cnt[1] = 3; exp_cnt[2] = 2; exp_cnt[3] = 0; exp_cnt[4] = 2;
        set_cfg(131, 0);
        set_cfg(130, 0);
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        fill_ramp(64, 0);
        send_pkt(64, 64, 0, 10, 129, 10);
        send_pkt(64, 64, 0, 0, 129, 0);
        send_pkt(20, 20, 0, -1, 0, 0);
        for (int i = 0; i < 47; i++) exp_q.push_back({i == 46, 32'(i)});
        for (int i = 0; i < 10; i++) exp_q.push_back({i == 9, 32'(i)});
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL cfg_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL cfg_word%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        for (int a = 0; a <= 4; a++) begin
            rd_rb(a, v);
            checks++;
            if (v !== exp_cnt[a]) begin
                errors++;
                $display("FAIL cfg_rb%0d got %h exp %h", a, v, exp_cnt[a]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] v;
        logic [63:0] exp_cnt [1:4];
        int off, keep, len;
        for (int a = 1; a <= 4; a++) exp_cnt[a] = 0;
        set_cfg(131, 0);
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        rand_mode = 1'b1;
        off = 0;
        keep = 0;
        for (int p = 0; p < 1000; p++) begin
            if (p % 50 == 0) begin
                off  = int'($urandom_range(0, 5));
                keep = int'($urandom_range(0, 25));
                set_cfg(130, 32'(off));
                set_cfg(129, 32'(keep));
            end
            len = int'($urandom_range(1, 30));
            pkt_data.delete();
            for (int i = 0; i < len; i++) pkt_data.push_back($urandom);
            for (int i = 0; i < len; i++)
                if (i >= off && i < off + keep)
                    exp_q.push_back({(i == len - 1) || (i == off + keep - 1), pkt_data[i]});
            exp_cnt[1] += 1;
            if (keep != 0 && len > off)        exp_cnt[2] += 1;
            if (keep != 0 && len < off + keep) exp_cnt[3] += 1;
            if (keep != 0 && len > off + keep) exp_cnt[4] += 1;
            send_pkt(len, len, 30, -1, 0, 0);
        end
        drain();
        rand_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL random_word%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
        for (int a = 1; a <= 4; a++) begin
            rd_rb(a, v);
            checks++;
            if (v !== exp_cnt[a]) begin
                errors++;
                $display("FAIL random_rb%0d got %0d exp %0d", a, v, exp_cnt[a]);
            end
        end
    endtask

    task automatic test_reset_midpacket();
        logic [63:0] v;
        fill_ramp(64, 32'h500);
        send_pkt(10, 64, 0, -1, 0, 0);
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (out_TVALID !== 1'b0 || in_TREADY !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got valid=%0b ready=%0b exp 0 0", out_TVALID, in_TREADY);
        end
        repeat (2) @(posedge clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge clk); #1;
        rd_rb(0, v);
        checks++;
        if (v !== 64'h0000002F_00000000) begin
            errors++;
            $display("FAIL rst_cfg got %h exp 0000002f00000000", v);
        end
        for (int a = 1; a <= 4; a++) begin
            rd_rb(a, v);
            checks++;
            if (v !== 64'd0) begin
                errors++;
                $display("FAIL rst_rb%0d got %0d exp 0", a, v);
            end
        end
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        fill_ramp(64, 0);
        send_pkt(64, 64, 0, -1, 0, 0);
        for (int i = 0; i < 47; i++) exp_q.push_back({i == 46, 32'(i)});
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rst_pkt_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL rst_pkt_word%0d got %h exp %h", k, got_q[k], exp_q[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_offset();
        test_short();
        test_cfg_midpacket();
        test_random();
        test_reset_midpacket();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
